// File: rtl/int_ctrl.sv
// ============================================================================
// Module   : int_ctrl
// Purpose  : Memory-mapped multi-source interrupt controller for jacaranda-8.
//            Optional round-robin arbitration: define INT_CTRL_RR_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl #(
    parameter int                N_SRC     = 4,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'd232
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_hit,
    output logic              int_req,
    input  logic              int_ack,
    output logic [DATA_W-1:0] int_vec,
    output logic [DATA_W-1:0] int_en,
    output logic              busy
);

    localparam int c_MAP_LEN = 4 + N_SRC;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    logic [N_SRC-1:0]  r_pend;
    logic [N_SRC-1:0]  r_mask;
    logic [N_SRC-1:0]  r_src_q;
    logic [DATA_W-1:0] r_vec [N_SRC];
    state_t            r_state;
    logic [2:0]        r_id;
    logic              r_int_req;
    logic              r_busy;
    logic [DATA_W-1:0] r_int_vec;
    logic [DATA_W-1:0] r_int_en;
`ifdef INT_CTRL_RR_PRIO_EN
    logic [2:0]        r_ptr;
`endif

    logic [ADDR_W-1:0] w_off;
    logic              w_wr;
    logic [N_SRC-1:0]  w_edge;
    logic [N_SRC-1:0]  w_w1c;
    logic [N_SRC-1:0]  w_elig;
    logic [N_SRC-1:0]  w_id_oh;
    logic              w_id_pend;
    logic              w_id_mask;
    logic              w_id_w1c;
    logic              w_sel_valid;
    logic [2:0]        w_sel_id;
    logic [DATA_W-1:0] w_sel_vec;
    logic [DATA_W-1:0] w_cur;

    assign w_off   = addr - BASE_ADDR;
    assign r_hit   = (addr >= BASE_ADDR) && (w_off < ADDR_W'(c_MAP_LEN));
    assign w_wr    = w_en && r_hit;
    assign w_edge  = src_in & ~r_src_q;
    assign w_w1c   = (w_wr && (w_off == ADDR_W'(0))) ? w_data[N_SRC-1:0] : '0;
    assign w_elig  = r_pend & r_mask;
    assign w_id_oh = N_SRC'(1) << r_id;

    assign w_id_pend = |(r_pend & w_id_oh);
    assign w_id_mask = |(r_mask & w_id_oh);
    assign w_id_w1c  = |(w_w1c & w_id_oh);

    assign int_req = r_int_req;
    assign int_vec = r_int_vec;
    assign int_en  = r_int_en;
    assign busy    = r_busy;

`ifdef INT_CTRL_RR_PRIO_EN
    // Nearest eligible source at or after the rotating pointer wins.
    always_comb begin
        int w_best;
        int w_dist;
        w_best      = N_SRC;
        w_dist      = 0;
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_dist = (i + N_SRC - int'(r_ptr)) % N_SRC;
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_sel_valid = 1'b1;
                w_sel_id    = 3'(i);
            end
        end
    end
`else
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel_valid = 1'b1;
                w_sel_id    = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        w_sel_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_sel_id == 3'(i)) w_sel_vec = r_vec[i];
        end
    end

    always_comb begin
        w_cur = '0;
        if (r_state != S_IDLE) begin
            w_cur[DATA_W-1] = 1'b1;
            w_cur[2:0]      = r_id;
        end
    end

    always_comb begin
        r_data = '0;
        if (r_hit) begin
            if (w_off == ADDR_W'(0)) r_data = DATA_W'(r_pend);
            if (w_off == ADDR_W'(1)) r_data = DATA_W'(r_mask);
            if (w_off == ADDR_W'(2)) r_data = w_cur;
            for (int i = 0; i < N_SRC; i++) begin
                if (w_off == ADDR_W'(4 + i)) r_data = r_vec[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pend    <= '0;
            r_mask    <= '0;
            r_src_q   <= '0;
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_int_req <= 1'b0;
            r_busy    <= 1'b0;
            r_int_vec <= '0;
            r_int_en  <= DATA_W'(1);
            for (int i = 0; i < N_SRC; i++) r_vec[i] <= '0;
`ifdef INT_CTRL_RR_PRIO_EN
            r_ptr     <= '0;
`endif
        end else begin
            r_src_q <= src_in;
            // A new edge on a bit being cleared in the same cycle keeps it set.
            r_pend  <= (r_pend & ~w_w1c) | w_edge;
            if (w_wr && (w_off == ADDR_W'(1))) r_mask <= w_data[N_SRC-1:0];
            for (int i = 0; i < N_SRC; i++) begin
                if (w_wr && (w_off == ADDR_W'(4 + i))) r_vec[i] <= w_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        r_state   <= S_REQ;
                        r_id      <= w_sel_id;
                        r_int_vec <= w_sel_vec;
                        r_int_req <= 1'b1;
                        r_int_en  <= '0;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        r_state   <= S_SERVICE;
                        r_int_req <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef INT_CTRL_RR_PRIO_EN
                        r_ptr     <= 3'((int'(r_id) + 1) % N_SRC);
`endif
                    end else if (!w_id_mask) begin
                        r_state   <= S_IDLE;
                        r_int_req <= 1'b0;
                        r_int_en  <= DATA_W'(1);
                    end
                end
                S_SERVICE: begin
                    // The ISR's W1C ends service even if a fresh edge re-sets the bit.
                    if (w_id_w1c || !w_id_pend) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_int_en <= DATA_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module   : tb_int_ctrl
// Purpose  : Self-checking bench for int_ctrl (directed table, corner
//            sequences, randomized run against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

    localparam int          N     = 4;
    localparam logic [7:0]  c_BASE = 8'd232;

    logic       clock;
    logic       reset;
    logic [3:0] src_in;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       r_hit;
    logic       int_req;
    logic       int_ack;
    logic [7:0] int_vec;
    logic [7:0] int_en;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    int_ctrl #(.N_SRC(N), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(c_BASE)) dut (
        .clock   (clock),
        .reset   (reset),
        .src_in  (src_in),
        .addr    (addr),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_data  (r_data),
        .r_hit   (r_hit),
        .int_req (int_req),
        .int_ack (int_ack),
        .int_vec (int_vec),
        .int_en  (int_en),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: controller is either free, or owns one source that is
    // waiting for the CPU (not acked) or being serviced (acked).
    logic [3:0] m_pend, m_mask, m_srcq;
    logic [7:0] m_vec [N];
    bit         m_active, m_acked;
    int         m_id, m_ptr;
    logic [7:0] m_ivec;

    function automatic bit m_hit(input logic [7:0] a);
        return (a >= c_BASE) && (int'(a) - int'(c_BASE) < 4 + N);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int off;
        off = int'(a) - int'(c_BASE);
        if (!m_hit(a)) return 8'h00;
        case (off)
            0: return {4'h0, m_pend};
            1: return {4'h0, m_mask};
            2: return m_active ? (8'h80 | 8'(m_id)) : 8'h00;
            3: return 8'h00;
            default: return m_vec[off - 4];
        endcase
    endfunction

    task automatic model_update();
        logic [3:0] edg, w1c, elig;
        int off, pick;
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_srcq = '0;
            for (int i = 0; i < N; i++) m_vec[i] = '0;
            m_active = 0; m_acked = 0; m_id = 0; m_ptr = 0; m_ivec = '0;
        end else begin
            off  = int'(addr) - int'(c_BASE);
            edg  = src_in & ~m_srcq;
            w1c  = (w_en && m_hit(addr) && off == 0) ? w_data[3:0] : 4'h0;
            elig = m_pend & m_mask;
            if (!m_active) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (pick < 0 && elig[i]) pick = i;
                end
                if (pick >= 0) begin
                    m_active = 1; m_acked = 0; m_id = pick; m_ivec = m_vec[pick];
                end
            end else if (!m_acked) begin
                if (int_ack) begin
                    m_acked = 1;
`ifdef INT_CTRL_RR_PRIO_EN
                    m_ptr = (m_id + 1) % N;
`endif
                end else if (!m_mask[m_id]) begin
                    m_active = 0;
                end
            end else if (w1c[m_id] || !m_pend[m_id]) begin
                m_active = 0;
            end
            m_pend = (m_pend & ~w1c) | edg;
            if (w_en && m_hit(addr) && off == 1) m_mask = w_data[3:0];
            if (w_en && m_hit(addr) && off >= 4) m_vec[off - 4] = w_data;
            m_srcq = src_in;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [7:0] a, input logic [7:0] wd,
                        input logic we, input logic ack, input logic rst);
        src_in = s; addr = a; w_data = wd; w_en = we; int_ack = ack; reset = rst;
        @(posedge clock);
        model_update();
        #1;
        chk("int_req", 32'(int_req), 32'(m_active && !m_acked));
        chk("busy",    32'(busy),    32'(m_active && m_acked));
        chk("int_en",  32'(int_en),  m_active ? 32'h0 : 32'h1);
        chk("int_vec", 32'(int_vec), 32'(m_ivec));
        chk("r_data",  32'(r_data),  32'(m_read(a)));
        chk("r_hit",   32'(r_hit),   32'(m_hit(a)));
    endtask

    task automatic do_reset();
        step(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct packed {
        logic [3:0] src;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       we;
        logic       ack;
        logic       req;
        logic [7:0] vec;
        logic [7:0] en;
        logic       busy;
        logic [7:0] rd;
        logic       hit;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Basic request/ack/W1C flow for source 2
        tbl[0]  = '{4'h0, 8'd233, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h0F, 1'b1};
        tbl[1]  = '{4'h0, 8'd238, 8'h40, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h40, 1'b1};
        tbl[2]  = '{4'h4, 8'd234, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{4'h0, 8'd234, 8'h00, 1'b0, 1'b0, 1'b1, 8'h40, 8'h00, 1'b0, 8'h82, 1'b1};
        tbl[4]  = '{4'h0, 8'd232, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 8'h04, 1'b1};
        tbl[5]  = '{4'h0, 8'd232, 8'h04, 1'b1, 1'b0, 1'b0, 8'h40, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 8'h01, 1'b0, 8'h00, 1'b1};
        // Masked pending bit stays latched, requests once unmasked
        tbl[7]  = '{4'h0, 8'd233, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{4'h1, 8'd232, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 8'h01, 1'b0, 8'h01, 1'b1};
        tbl[9]  = '{4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 8'h01, 1'b0, 8'h01, 1'b1};
        tbl[10] = '{4'h0, 8'd233, 8'h01, 1'b1, 1'b0, 1'b0, 8'h40, 8'h01, 1'b0, 8'h01, 1'b1};
        tbl[11] = '{4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h01, 1'b1};
        tbl[12] = '{4'h0, 8'd232, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1};
        tbl[13] = '{4'h0, 8'd232, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1};
        // Map boundaries and unimplemented mask bits
        tbl[14] = '{4'h0, 8'd235, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[15] = '{4'h0, 8'd231, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0};
        tbl[16] = '{4'h0, 8'd233, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h0F, 1'b1};
        tbl[17] = '{4'h0, 8'd239, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[18] = '{4'h0, 8'd240, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0};

        do_reset();
        for (int r = 0; r < 19; r++) begin
            step(tbl[r].src, tbl[r].addr, tbl[r].wd, tbl[r].we, tbl[r].ack, 1'b1);
            chk($sformatf("tbl%0d.int_req", r), 32'(int_req), 32'(tbl[r].req));
            chk($sformatf("tbl%0d.int_vec", r), 32'(int_vec), 32'(tbl[r].vec));
            chk($sformatf("tbl%0d.int_en",  r), 32'(int_en),  32'(tbl[r].en));
            chk($sformatf("tbl%0d.busy",    r), 32'(busy),    32'(tbl[r].busy));
            chk($sformatf("tbl%0d.r_data",  r), 32'(r_data),  32'(tbl[r].rd));
            chk($sformatf("tbl%0d.r_hit",   r), 32'(r_hit),   32'(tbl[r].hit));
        end

        // Simultaneous sources 1 and 3: lower index first, then the other
        do_reset();
        step(4'h0, 8'd237, 8'h10, 1'b1, 1'b0, 1'b1);
        step(4'h0, 8'd239, 8'h30, 1'b1, 1'b0, 1'b1);
        step(4'h0, 8'd233, 8'h0F, 1'b1, 1'b0, 1'b1);
        step(4'hA, 8'd232, 8'h00, 1'b0, 1'b0, 1'b1);
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("two_src.first_req", 32'(int_req), 32'h1);
        chk("two_src.first_vec", 32'(int_vec), 32'h10);
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b1, 1'b1);
        step(4'h0, 8'd232, 8'h02, 1'b1, 1'b0, 1'b1);
        chk("two_src.pend_left", 32'(r_data), 32'h08);
        step(4'h0, 8'd234, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("two_src.second_vec", 32'(int_vec), 32'h30);
        chk("two_src.second_cur", 32'(r_data), 32'h83);
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b1, 1'b1);
        step(4'h0, 8'd232, 8'h08, 1'b1, 1'b0, 1'b1);

        // W1C and new edge on the serviced bit in the same cycle
        do_reset();
        step(4'h0, 8'd233, 8'h01, 1'b1, 1'b0, 1'b1);
        step(4'h1, 8'd232, 8'h00, 1'b0, 1'b0, 1'b1);
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b1);
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("w1c_race.busy", 32'(busy), 32'h1);
        step(4'h1, 8'd232, 8'h01, 1'b1, 1'b0, 1'b1);
        chk("w1c_race.pend", 32'(r_data), 32'h01);
        chk("w1c_race.idle_en", 32'(int_en), 32'h01);
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("w1c_race.rereq", 32'(int_req), 32'h1);

        // Reset while in REQ
        step(4'h0, 8'd232, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("mid_reset.int_req", 32'(int_req), 32'h0);
        chk("mid_reset.int_en",  32'(int_en),  32'h01);
        chk("mid_reset.pend",    32'(r_data),  32'h00);
        step(4'h0, 8'd233, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("mid_reset.mask",    32'(r_data),  32'h00);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step(4'($urandom_range(0, 15)),
                 8'(230 + $urandom_range(0, 11)),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 299) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
